alu_seq_ctrl: RTL

Control unit that sequences the Phase-1 Datapath through fetch and execute of one register-to-register ALU instruction. It drives the datapath's `enable` and `busSelect` one-hot vectors, `MR_Read` and `Control_Signals`, stepping one control step (T0–T5) per clock. It decodes the opcode from the IR contents fed back from the datapath. It replaces hand-written testbench sequencing as the first piece of the real control path.

---
 rtl/alu_seq_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Control sequencer for one register-to-register ALU instruction.
// Steps T0-T5 drive the datapath's enables, bus selects and ALU op.
module alu_seq_ctrl #(
  parameter int Y_BIT   = 19,
  parameter int PC_BIT  = 20,
  parameter int MDR_BIT = 21,
  parameter int ZLO_BIT = 22,
  parameter int IR_BIT  = 23,
  parameter int Z_BIT   = 24,
  parameter int MAR_BIT = 25
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic        MR_Read,
  output logic [3:0]  Control_Signals,
  output logic        pc_inc,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2,
    S_T3, S_T4, S_T5, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0] ra, rc, op;
  logic       una, bad;
  logic [3:0] dec_op;
  logic       dec_una;
  logic [3:0] rb;
  logic       unused;

  assign rb      = ir[22:19];
  assign unused  = ^ir[14:0];
  assign dec_una = (dec_op == 4'd5) || (dec_op == 4'd6);

  // Zero means the opcode is not an ALU instruction.
  always_comb begin
    unique case (ir[31:27])
      5'b00011: dec_op = 4'd1;
      5'b00100: dec_op = 4'd2;
      5'b00101: dec_op = 4'd3;
      5'b00110: dec_op = 4'd4;
      5'b10001: dec_op = 4'd5;
      5'b10010: dec_op = 4'd6;
      5'b00111: dec_op = 4'd7;
      5'b01000: dec_op = 4'd8;
      5'b01001: dec_op = 4'd9;
      5'b01010: dec_op = 4'd10;
      default:  dec_op = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= S_IDLE;
      ra    <= '0;
      rc    <= '0;
      op    <= '0;
      una   <= 1'b0;
      bad   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_T3) begin
        ra  <= ir[26:23];
        rc  <= ir[18:15];
        op  <= dec_op;
        una <= dec_una;
        bad <= (dec_op == 4'd0);
      end else if (state == S_DONE) begin
        bad <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx        = state;
    enable          = '0;
    busSelect       = '0;
    MR_Read         = 1'b0;
    Control_Signals = '0;
    pc_inc          = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_T0;
      end
      S_T0: begin
        busy              = 1'b1;
        busSelect[PC_BIT] = 1'b1;
        enable[MAR_BIT]   = 1'b1;
        enable[PC_BIT]    = 1'b1;
        pc_inc            = 1'b1;
        state_nx          = S_T1;
      end
      S_T1: begin
        busy            = 1'b1;
        MR_Read         = 1'b1;
        enable[MDR_BIT] = 1'b1;
        state_nx        = S_T2;
      end
      S_T2: begin
        busy               = 1'b1;
        busSelect[MDR_BIT] = 1'b1;
        enable[IR_BIT]     = 1'b1;
        state_nx           = S_T3;
      end
      // IR was loaded at the end of T2, so decode it live here.
      S_T3: begin
        busy = 1'b1;
        if (dec_op == 4'd0) begin
          state_nx = S_DONE;
        end else begin
          busSelect[rb] = 1'b1;
          if (dec_una) begin
            enable[Z_BIT]   = 1'b1;
            Control_Signals = dec_op;
          end else begin
            enable[Y_BIT] = 1'b1;
          end
          state_nx = S_T4;
        end
      end
      S_T4: begin
        busy = 1'b1;
        if (una) begin
          busSelect[ZLO_BIT] = 1'b1;
          enable[ra]         = 1'b1;
          state_nx           = S_DONE;
        end else begin
          busSelect[rc]   = 1'b1;
          enable[Z_BIT]   = 1'b1;
          Control_Signals = op;
          state_nx        = S_T5;
        end
      end
      S_T5: begin
        busy               = 1'b1;
        busSelect[ZLO_BIT] = 1'b1;
        enable[ra]         = 1'b1;
        state_nx           = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        illegal  = bad;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
